shadow_reg_ctrl: RTL and testbench
==================================

Name: shadow_reg_ctrl

Overview:
- Parametrised two-phase shadowed control register for crypto-core control fields, e.g. the AES control word.
- Software must write the same value twice to commit it.
- The committed value is held twice: a true copy and an inverted shadow copy. Any divergence between them is flagged as a storage fault.
- Beyond the single-shot shadow register, it adds a hardware write path, a staged-phase timeout and per-event error outputs.

Parameters:
WIDTH, 32, register data width in bits (1..64).
RESVAL, '0, reset value of the committed register, WIDTH bits.
TIMEOUT, 16, cycles allowed between first and second write; 0 disables the timeout.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
we_i  input  1  software write strobe.
wd_i  input  WIDTH  software write data.
re_i  input  1  software read strobe; aborts a pending staged phase.
de_i  input  1  hardware write enable; bypasses the two-phase protocol.
d_i  input  WIDTH  hardware write data.
q_o  output  WIDTH  committed value.
qs_o  output  WIDTH  software read-back value; equals q_o.
phase_o  output  1  1 = first write staged, awaiting confirmation.
err_update_o  output  1  one-cycle pulse on a second-write mismatch.
err_timeout_o  output  1  one-cycle pulse when the staged phase expires.
err_storage_o  output  1  sticky flag: committed copy is not equal to ~shadow copy.

Behaviour:
- Internal registers:
  - committed: resets to RESVAL.
  - shadow: resets to ~RESVAL.
  - staged: resets to '0.
  - timeout counter: resets to 0, width $clog2(TIMEOUT+1).
  - FSM state: resets to IDLE.
- Output reset values: q_o = RESVAL, phase_o = 0, all err_* = 0. Reset acts immediately, including mid-phase.
- FSM IDLE:
  - we_i & !de_i: staged <= ~wd_i, counter <= 0, go to STAGED.
- FSM STAGED:
  - we_i & !de_i with wd_i == ~staged: committed <= wd_i, shadow <= ~wd_i, go to IDLE.
  - we_i & !de_i with mismatch: err_update_o pulses next cycle; committed is unchanged; go to IDLE.
  - re_i & !we_i: go to IDLE silently.
  - TIMEOUT != 0: the counter increments each STAGED cycle without we_i. When it reaches TIMEOUT-1 and no we_i is present, err_timeout_o pulses next cycle and the FSM returns to IDLE. A write arriving on that same cycle is processed normally and no timeout fires.
- Hardware write (de_i), in any state:
  - committed <= d_i, shadow <= ~d_i, go to IDLE.
  - A concurrent we_i is dropped, with no error pulse.
- Simultaneous we_i and re_i: the write is processed; the read-abort is ignored.
- Latency: q_o reflects a commit or hardware write on the cycle after the strobe. phase_o is registered (it is the FSM state).
- err_storage_o:
  - Set the cycle after committed != ~shadow is observed.
  - Stays set until reset; writes never clear it.
  - The check is continuous, bitwise across all WIDTH bits.
- The staged register never drives q_o.

Optional Feature:
- Macro: SHADOW_REG_ERR_INJECT_EN.
- Defined:
  - Adds input port inject_i (1 bit).
  - On a cycle with inject_i=1, shadow[0] is inverted at the next edge.
  - err_storage_o rises one cycle after that.
  - Injection has lower priority than a de_i write or a commit in the same cycle: the write wins and no fault is created.
- Undefined: the port is absent, and the shadow copy changes only through commit, de_i or reset.

Test Plan (WIDTH=32, RESVAL=32'h0000_00A5, TIMEOUT=8):
1. Reset then idle → q_o=32'h0000_00A5, phase_o=0, all err_*=0.
2. we_i with wd_i=32'h1234_5678, then we_i with 32'h1234_5678 two cycles later → phase_o=1 between the writes; q_o=32'h1234_5678 one cycle after the second write; no errors.
3. we_i 32'hDEAD_BEEF, then we_i 32'hDEAD_BEEE → err_update_o pulses once; q_o unchanged at 32'h0000_00A5; phase_o=0.
4. we_i 32'hCAFE_0001, then no activity for 8 cycles → err_timeout_o pulses once; phase_o=0; a following single we_i only re-stages and does not commit.
5. Staged phase, then de_i=1 with d_i=32'h0000_FFFF and we_i=1 with wd_i equal to the staged value in the same cycle → q_o=32'h0000_FFFF; phase_o=0; no err_update_o.
6. With SHADOW_REG_ERR_INJECT_EN defined: inject_i pulse → err_storage_o=1 one cycle later. It stays 1 through subsequent commits of 32'h1111_1111 and clears only when rst_i is asserted.

Source files
------------

// File: rtl/shadow_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shadow_reg_ctrl
//
// Two-phase shadowed control register for crypto-core control fields.
// Software must write the same value twice in a row to commit it. The
// committed value is stored as a true copy plus an inverted shadow copy, and
// any divergence between the two raises a sticky storage fault. A hardware
// write path (de_i) bypasses the two-phase protocol. A staged first write
// expires after TIMEOUT idle cycles.
//
// Optional feature: define SHADOW_REG_ERR_INJECT_EN to add inject_i, which
// flips shadow[0] so the storage-fault path can be exercised.
//
// Parameters:
//   WIDTH    data width in bits (1..64)
//   RESVAL   reset value of the committed register
//   TIMEOUT  cycles allowed between first and second write (0 = no timeout)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   we_i, wd_i     software write strobe / data
//   re_i           software read strobe; aborts a pending staged phase
//   de_i, d_i      hardware write enable / data (wins over everything)
//   inject_i       (SHADOW_REG_ERR_INJECT_EN only) flip shadow[0]
//   q_o, qs_o      committed value / software read-back (identical)
//   phase_o        1 = first write staged, awaiting confirmation
//   err_update_o   one-cycle pulse on a second-write mismatch
//   err_timeout_o  one-cycle pulse when the staged phase expires
//   err_storage_o  sticky: committed != ~shadow was observed
// -----------------------------------------------------------------------------
module shadow_reg_ctrl #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RESVAL  = '0,
  parameter int               TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             re_i,
  input  logic             de_i,
  input  logic [WIDTH-1:0] d_i,
`ifdef SHADOW_REG_ERR_INJECT_EN
  input  logic             inject_i,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qs_o,
  output logic             phase_o,
  output logic             err_update_o,
  output logic             err_timeout_o,
  output logic             err_storage_o
);

  // Counter is kept at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int             CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] staged_q, staged_d;
  logic [WIDTH-1:0] committed_q, committed_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_update_q, err_update_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_storage_q, err_storage_d;
  logic             commit;

  // Next-state and datapath decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave a variable unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    staged_d      = staged_q;
    committed_d   = committed_q;
    shadow_d      = shadow_q;
    err_update_d  = 1'b0;
    err_timeout_d = 1'b0;
    commit        = 1'b0;

    if (de_i) begin
      // Hardware write wins; any concurrent software write is dropped silently.
      committed_d = d_i;
      shadow_d    = ~d_i;
      cnt_d       = '0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (we_i) begin
            // Staged value is held inverted so it never looks like q.
            staged_d = ~wd_i;
            cnt_d    = '0;
            state_d  = STAGED;
          end
        end
        STAGED: begin
          if (we_i) begin
            // A write (even alongside re_i or on the expiry cycle) is processed.
            state_d = IDLE;
            if (wd_i == ~staged_q) begin
              commit      = 1'b1;
              committed_d = wd_i;
              shadow_d    = ~wd_i;
            end else begin
              err_update_d = 1'b1;
            end
          end else if (re_i) begin
            state_d = IDLE;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
          end else if (TO_EN) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef SHADOW_REG_ERR_INJECT_EN
    // Fault injection yields to any real update of the shadow copy.
    if (inject_i && !de_i && !commit) begin
      shadow_d[0] = ~shadow_q[0];
    end
`endif

    // Continuous bitwise integrity check; sticky until reset.
    err_storage_d = err_storage_q | (committed_q != ~shadow_q);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: these are individual flops, not a RAM, so every one of them is
    // reset; all sequential assignments are non-blocking to avoid races.
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      staged_q      <= '0;
      committed_q   <= RESVAL;
      shadow_q      <= ~RESVAL;
      err_update_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_storage_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      staged_q      <= staged_d;
      committed_q   <= committed_d;
      shadow_q      <= shadow_d;
      err_update_q  <= err_update_d;
      err_timeout_q <= err_timeout_d;
      err_storage_q <= err_storage_d;
    end
  end

  // The staged register never reaches the outputs.
  assign q_o           = committed_q;
  assign qs_o          = committed_q;
  assign phase_o       = (state_q == STAGED);
  assign err_update_o  = err_update_q;
  assign err_timeout_o = err_timeout_q;
  assign err_storage_o = err_storage_q;

endmodule

// File: tb/tb_shadow_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shadow_reg_ctrl
//
// Directed, table-driven bench for shadow_reg_ctrl with WIDTH=32,
// RESVAL=32'h0000_00A5, TIMEOUT=8. Inputs are driven 1 ns after a rising
// edge and outputs are compared 1 ns after the next rising edge, so each
// vector's expected values describe the state produced by that edge.
// -----------------------------------------------------------------------------
module tb_shadow_reg_ctrl;

  localparam int          W      = 32;
  localparam logic [31:0] RESVAL = 32'h0000_00A5;
  localparam int          TO     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we  = 1'b0;
  logic [W-1:0]  wd  = '0;
  logic          re  = 1'b0;
  logic          de  = 1'b0;
  logic [W-1:0]  d   = '0;
  logic          inject = 1'b0;
  logic [W-1:0]  q, qs;
  logic          phase, err_upd, err_to, err_sto;

  int vec_count   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shadow_reg_ctrl #(
    .WIDTH  (W),
    .RESVAL (RESVAL),
    .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .we_i         (we),
    .wd_i         (wd),
    .re_i         (re),
    .de_i         (de),
    .d_i          (d),
`ifdef SHADOW_REG_ERR_INJECT_EN
    .inject_i     (inject),
`endif
    .q_o          (q),
    .qs_o         (qs),
    .phase_o      (phase),
    .err_update_o (err_upd),
    .err_timeout_o(err_to),
    .err_storage_o(err_sto)
  );

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        de;
    logic [31:0] d;
    logic [31:0] exp_q;
    logic        exp_ph;
    logic        exp_upd;
    logic        exp_to;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic w, logic [31:0] wdat, logic r, logic h,
                              logic [31:0] hdat, logic [31:0] eq, logic ep,
                              logic eu, logic et);
    vec_t v;
    v.we = w;  v.wd = wdat; v.re = r; v.de = h; v.d = hdat;
    v.exp_q = eq; v.exp_ph = ep; v.exp_upd = eu; v.exp_to = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] eq,
                           input logic ep, input logic eu, input logic et,
                           input logic es);
    check({tag, ".q"},       64'(q),       64'(eq));
    check({tag, ".qs"},      64'(qs),      64'(eq));
    check({tag, ".phase"},   64'(phase),   64'(ep));
    check({tag, ".err_upd"}, 64'(err_upd), 64'(eu));
    check({tag, ".err_to"},  64'(err_to),  64'(et));
    check({tag, ".err_sto"}, 64'(err_sto), 64'(es));
  endtask

  // Apply one cycle of inputs and land 1 ns after the consuming edge.
  task automatic step(input logic w, input logic [31:0] wdat, input logic r,
                      input logic h, input logic [31:0] hdat, input logic inj);
    we = w; wd = wdat; re = r; de = h; d = hdat; inject = inj;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; de = 1'b0; inject = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Mismatch first so q is still at RESVAL, then commits, aborts, de_i.
    vecs[0]  = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_00A5, 0, 0, 0);
    vecs[1]  = mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0000_00A5, 1, 0, 0);
    vecs[2]  = mk(1, 32'hDEAD_BEEE, 0, 0, 32'h0,         32'h0000_00A5, 0, 1, 0);
    vecs[3]  = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_00A5, 0, 0, 0);
    vecs[4]  = mk(1, 32'h1234_5678, 0, 0, 32'h0,         32'h0000_00A5, 1, 0, 0);
    vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_00A5, 1, 0, 0);
    vecs[6]  = mk(1, 32'h1234_5678, 0, 0, 32'h0,         32'h1234_5678, 0, 0, 0);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,         32'h1234_5678, 0, 0, 0);
    vecs[8]  = mk(1, 32'h0000_AAAA, 0, 0, 32'h0,         32'h1234_5678, 1, 0, 0);
    vecs[9]  = mk(0, 32'h0,         1, 0, 32'h0,         32'h1234_5678, 0, 0, 0);
    vecs[10] = mk(1, 32'h0000_AAAA, 0, 0, 32'h0,         32'h1234_5678, 1, 0, 0);
    vecs[11] = mk(1, 32'h0000_AAAA, 1, 0, 32'h0,         32'h0000_AAAA, 0, 0, 0);
    vecs[12] = mk(1, 32'h0000_0055, 0, 0, 32'h0,         32'h0000_AAAA, 1, 0, 0);
    vecs[13] = mk(1, 32'h0000_0055, 0, 1, 32'h0000_FFFF, 32'h0000_FFFF, 0, 0, 0);
    vecs[14] = mk(0, 32'h0,         0, 0, 32'h0,         32'h0000_FFFF, 0, 0, 0);
    vecs[15] = mk(0, 32'h0,         0, 1, 32'h0000_0001, 32'h0000_0001, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", RESVAL, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].de, vecs[i].d, 1'b0);
      check_out($sformatf("v%0d", i), vecs[i].exp_q, vecs[i].exp_ph,
                vecs[i].exp_upd, vecs[i].exp_to, 1'b0);
    end

    // Timeout: 7 idle cycles keep the phase, the 8th expires it.
    step(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, '0, 1'b0);
    check_out("to_stage", 32'h1, 1, 0, 0, 0);
    for (int k = 1; k < TO; k++) begin
      idle();
      check_out($sformatf("to_wait%0d", k), 32'h1, 1, 0, 0, 0);
    end
    idle();
    check_out("to_fire", 32'h1, 0, 0, 1, 0);
    idle();
    check_out("to_pulse_end", 32'h1, 0, 0, 0, 0);
    step(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, '0, 1'b0);
    check_out("to_restage", 32'h1, 1, 0, 0, 0);
    idle();
    check_out("to_restage_hold", 32'h1, 1, 0, 0, 0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check_out("to_abort", 32'h1, 0, 0, 0, 0);

    // Confirmation landing exactly on the expiry cycle commits, no timeout.
    step(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k < TO; k++) idle();
    check_out("edge_wait", 32'h1, 1, 0, 0, 0);
    step(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, '0, 1'b0);
    check_out("edge_commit", 32'h0BAD_F00D, 0, 0, 0, 0);
    idle();
    check_out("edge_after", 32'h0BAD_F00D, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a staged phase.
    step(1'b1, 32'h7777_0000, 1'b0, 1'b0, '0, 1'b0);
    check_out("mid_stage", 32'h0BAD_F00D, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_out("mid_reset", RESVAL, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h7777_0000, 1'b0, 1'b0, '0, 1'b0);
    check_out("post_reset_stage", RESVAL, 1, 0, 0, 0);
    step(1'b1, 32'h7777_0000, 1'b0, 1'b0, '0, 1'b0);
    check_out("post_reset_commit", 32'h7777_0000, 0, 0, 0, 0);

`ifdef SHADOW_REG_ERR_INJECT_EN
    // Injection flips shadow[0]; the fault flag follows one cycle later.
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_out("inj_edge", 32'h7777_0000, 0, 0, 0, 0);
    idle();
    check_out("inj_flag", 32'h7777_0000, 0, 0, 0, 1);
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0, '0, 1'b0);
    check_out("inj_commit", 32'h1111_1111, 0, 0, 0, 1);
    idle();
    check_out("inj_sticky", 32'h1111_1111, 0, 0, 0, 1);
    do_reset();
    check_out("inj_reset", RESVAL, 0, 0, 0, 0);
    // A hardware write in the same cycle beats the injection.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0007, 1'b1);
    idle();
    idle();
    check_out("inj_vs_de", 32'h0000_0007, 0, 0, 0, 0);
    // So does a commit.
    step(1'b1, 32'h0000_0009, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_0009, 1'b0, 1'b0, '0, 1'b1);
    idle();
    idle();
    check_out("inj_vs_commit", 32'h0000_0009, 0, 0, 0, 0);
`else
    do_reset();
    check_out("final_reset", RESVAL, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
